// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic constants for the adder datapath
//
// Purpose: constants shared by the adder interface and the adder top.
// Ports:   none (package).
package arith_pkg;

    // Operand width used when no WIDTH override is given (plain 1-bit full adder).
    localparam int FA_WIDTH_DEFAULT = 1;

endpackage : arith_pkg

// File: rtl/full_adder_if.sv
// rtl/full_adder_if.sv - operand/result bundle for the ripple-carry adder
//
// Purpose: groups the adder operands and results into one port.
// Signals:
//   a, b     WIDTH  operands
//   c        1      carry-in
//   sum      WIDTH  combinational sum
//   carry    1      combinational carry-out
//   sum_q    WIDTH  registered sum
//   carry_q  1      registered carry-out
// Modports: master drives operands, slave (the adder) drives results.
interface full_adder_if
    import arith_pkg::*;
#(
    parameter int WIDTH = FA_WIDTH_DEFAULT
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    modport master (
        output a, b, c,
        input  sum, carry, sum_q, carry_q
    );

    modport slave (
        input  a, b, c,
        output sum, carry, sum_q, carry_q
    );

endinterface : full_adder_if

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - one-bit full adder cell
//
// Purpose: single cell of the ripple-carry chain.
// Ports:
//   x, y  input   operand bits
//   ci    input   carry-in
//   s     output  sum bit
//   co    output  carry-out (majority of x, y, ci)
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    // Plain gate equations so X/Z on any input propagates to the outputs.
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule : full_adder_bit

// File: rtl/full_adder.sv
// rtl/full_adder.sv - parameterised ripple-carry adder with registered copy
//
// Purpose: {carry, sum} = a + b + c (unsigned, WIDTH+1 bits) built from WIDTH
//          chained one-bit cells, plus one register stage (sum_q, carry_q).
// Ports:
//   clk    input  rising-edge clock for the output registers
//   rst_n  input  asynchronous active-low reset, clears sum_q/carry_q only
//   bus    slave  operands a, b, c in; sum, carry, sum_q, carry_q out
module full_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = FA_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    full_adder_if.slave  bus
);

    // chain[i] is the carry into cell i; chain[WIDTH] is the final carry-out.
    logic [WIDTH:0]   chain;
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;

    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    assign chain[0] = bus.c;

    // Unpipelined ripple: the carry chain is the critical path by design.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_bit u_bit (
            .x  (bus.a[i]),
            .y  (bus.b[i]),
            .ci (chain[i]),
            .s  (sum_d[i]),
            .co (chain[i+1])
        );
    end

    assign carry_d = chain[WIDTH];

    // Reset touches only the register stage; the combinational path is free-running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign bus.sum     = sum_d;
    assign bus.carry   = carry_d;
    assign bus.sum_q   = sum_q;
    assign bus.carry_q = carry_q;

endmodule : full_adder

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - self-checking bench for full_adder at WIDTH 1, 8 and 16
module tb_full_adder;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    full_adder_if #(.WIDTH(1))  if1  ();
    full_adder_if #(.WIDTH(8))  if8  ();
    full_adder_if #(.WIDTH(16)) if16 ();

    full_adder #(.WIDTH(1))  u_w1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    full_adder #(.WIDTH(8))  u_w8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    full_adder #(.WIDTH(16)) u_w16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic on a WIDTH+1 bit result.
    function automatic logic [64:0] ref_add(input int w, input logic [63:0] a,
                                            input logic [63:0] b, input logic c);
        logic [64:0] mask;
        mask = (65'd1 << w) - 65'd1;
        return ((65'(a) & mask) + (65'(b) & mask) + 65'(c)) & ((mask << 1) | 65'd1);
    endfunction

    task automatic drive(input int w, input logic [63:0] a, input logic [63:0] b, input logic c);
        case (w)
            1:       begin if1.a  = a[0];    if1.b  = b[0];    if1.c  = c; end
            8:       begin if8.a  = a[7:0];  if8.b  = b[7:0];  if8.c  = c; end
            default: begin if16.a = a[15:0]; if16.b = b[15:0]; if16.c = c; end
        endcase
    endtask

    task automatic get(input int w, input bit reg_side, output logic [63:0] s, output logic cy);
        case (w)
            1:       begin s = reg_side ? 64'(if1.sum_q)  : 64'(if1.sum);  cy = reg_side ? if1.carry_q  : if1.carry;  end
            8:       begin s = reg_side ? 64'(if8.sum_q)  : 64'(if8.sum);  cy = reg_side ? if8.carry_q  : if8.carry;  end
            default: begin s = reg_side ? 64'(if16.sum_q) : 64'(if16.sum); cy = reg_side ? if16.carry_q : if16.carry; end
        endcase
    endtask

    task automatic chk_out(input string tag, input int w, input bit reg_side,
                           input logic [63:0] exp_s, input logic exp_c);
        logic [63:0] s;
        logic        cy;
        get(w, reg_side, s, cy);
        chk({tag, reg_side ? "_sum_q" : "_sum"}, s, exp_s);
        chk({tag, reg_side ? "_carry_q" : "_carry"}, 64'(cy), 64'(exp_c));
    endtask

    // Drive just after a rising edge, check combinational results on the falling edge.
    task automatic step(input string tag, input int w, input logic [63:0] a,
                        input logic [63:0] b, input logic c, output logic [64:0] full);
        @(posedge clk); #1;
        drive(w, a, b, c);
        full = ref_add(w, a, b, c);
        @(negedge clk);
        chk_out(tag, w, 1'b0, full[63:0] & ((64'd1 << w) - 64'd1), full[w]);
    endtask

    // Check registered outputs one edge later.
    task automatic reg_check(input string tag, input int w, input logic [64:0] full);
        @(posedge clk); #1;
        chk_out(tag, w, 1'b1, full[63:0] & ((64'd1 << w) - 64'd1), full[w]);
    endtask

    initial begin
        logic [64:0] full;
        logic [64:0] prev;
        logic [63:0] ra, rb;
        logic        rc;

        rst_n = 1'b0;
        drive(1, 0, 0, 0);
        drive(8, 0, 0, 0);
        drive(16, 0, 0, 0);
        #2;
        chk_out("rst_w1", 1, 1'b1, 0, 1'b0);
        chk_out("rst_w8", 8, 1'b1, 0, 1'b0);
        chk_out("rst_w16", 16, 1'b1, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 directed cases
        step("w1_111", 1, 1, 1, 1'b1, full);
        reg_check("w1_111", 1, full);
        step("w1_101", 1, 1, 0, 1'b1, full);
        step("w1_000", 1, 0, 0, 1'b0, full);
        step("w1_010", 1, 0, 1, 1'b0, full);

        // WIDTH=1 exhaustive sweep
        for (int i = 0; i < 8; i++) begin
            step($sformatf("w1_sweep%0d", i), 1, 64'(i[2]), 64'(i[1]), i[0], full);
            reg_check($sformatf("w1_sweep%0d", i), 1, full);
        end

        // WIDTH=8 boundaries
        step("w8_ff_00_1", 8, 64'hFF, 64'h00, 1'b1, full);
        chk("w8_ripple_const_sum", 64'(if8.sum), 64'h00);
        chk("w8_ripple_const_carry", 64'(if8.carry), 64'd1);
        reg_check("w8_ff_00_1", 8, full);
        step("w8_7f_01_0", 8, 64'h7F, 64'h01, 1'b0, full);
        chk("w8_7f_const_sum", 64'(if8.sum), 64'h80);
        chk("w8_7f_const_carry", 64'(if8.carry), 64'd0);
        reg_check("w8_7f_01_0", 8, full);

        // Asynchronous reset between edges
        step("rst_seq", 1, 1, 1, 1'b1, full);
        reg_check("rst_seq_load", 1, full);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst_async", 1, 1'b1, 0, 1'b0);
        chk_out("rst_comb_kept", 1, 1'b0, 1, 1'b1);
        @(posedge clk); #1;
        chk_out("rst_held", 1, 1'b1, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_out("rst_release_no_edge", 1, 1'b1, 0, 1'b0);
        @(posedge clk); #1;
        chk_out("rst_reload", 1, 1'b1, 1, 1'b1);

        // WIDTH=16 random: registered outputs lag combinational by one edge
        prev = '0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (i > 0) chk_out("w16_rand", 16, 1'b1, prev[15:0], prev[16]);
            ra = 64'($urandom_range(0, 65535));
            rb = 64'($urandom_range(0, 65535));
            rc = 1'($urandom_range(0, 1));
            drive(16, ra, rb, rc);
            prev = ref_add(16, ra, rb, rc);
            @(negedge clk);
            chk_out("w16_rand", 16, 1'b0, prev[15:0], prev[16]);
        end
        @(posedge clk); #1;
        chk_out("w16_rand_last", 16, 1'b1, prev[15:0], prev[16]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_full_adder
